// File: rtl/regfile_ctrl_pkg.sv
// Shared parameters for the register-file writeback controller.
//   AW      register address width
//   DW      data width
//   NREGS   physical registers r0..r14 (r15 is the PC and lives elsewhere)
//   CNT_W   width of each pending-write counter
//   CNT_MAX counter ceiling; a register at CNT_MAX blocks further issue
//   PC_IDX  address that aliases the PC
package regfile_ctrl_pkg;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NREGS = 15;
  localparam int CNT_W = 2;

  localparam logic [CNT_W-1:0] CNT_MAX = 2'd3;
  localparam logic [AW-1:0]    PC_IDX  = 4'hF;

  function automatic logic is_pc(input logic [AW-1:0] addr);
    return addr == PC_IDX;
  endfunction
endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the single register-file write port.
//   clk, reset_n   clock, asynchronous active-low reset
//   req0, addr0    ALU writeback request and its destination
//   req1, addr1    load/multiply writeback request and its destination
//   grant[1:0]     one-hot grant (bit0 = wb0, bit1 = wb1), zero when idle
// On a tie the requester that was not granted last wins, except that two
// writes to the same register always go to wb1 first: wb1 carries the
// older instruction, so its value must land before the younger one.
module wb_rr_arbiter
  import regfile_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic [1:0]    grant
);

  // 1 = wb1 was granted most recently; reset value lets wb0 win the first tie.
  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (req0 && req1) begin
      if (addr0 == addr1)  grant = 2'b10;
      else if (last_grant) grant = 2'b01;
      else                 grant = 2'b10;
    end else if (req0) begin
      grant = 2'b01;
    end else if (req1) begin
      grant = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (grant[1]) begin
      last_grant <= 1'b1;
    end else if (grant[0]) begin
      last_grant <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Owner of the register file's single write port (we3/wa3/wd3).
// Arbitrates ALU (wb0) and load/multiply (wb1) writebacks, tracks how many
// writes are outstanding per register, and flags read hazards for decode.
//   clk, reset_n              clock, asynchronous active-low reset
//   iss_valid/iss_dst/iss_ready  instruction issue into the scoreboard
//   wb0_valid/addr/data/ready    ALU writeback
//   wb1_valid/addr/data/ready    load/multiply writeback
//   rf_we/rf_wa/rf_wd         registered write port towards the regfile
//   chk_ra1/chk_ra2, hazard   decode source check; hazard = pending write
//   err_r15                   1-cycle pulse: writeback to r15 was dropped
//   err_unexp                 1-cycle pulse: writeback with nothing pending
//
// Handshake: a channel transfers on a clock edge where valid & ready are
// both high. ready is a pure combinational function of the current valids,
// addresses and scoreboard state; nothing is buffered, so a requester that
// is not granted must hold valid/addr/data and retry next cycle.
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_dst,
  output logic          iss_ready,
  input  logic          wb0_valid,
  input  logic [AW-1:0] wb0_addr,
  input  logic [DW-1:0] wb0_data,
  output logic          wb0_ready,
  input  logic          wb1_valid,
  input  logic [AW-1:0] wb1_addr,
  input  logic [DW-1:0] wb1_data,
  output logic          wb1_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  input  logic [AW-1:0] chk_ra1,
  input  logic [AW-1:0] chk_ra2,
  output logic          hazard,
  output logic          err_r15,
  output logic          err_unexp
);

  logic [CNT_W-1:0] cnt [NREGS];
  logic [1:0]       grant;

  logic             wb_fire;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic             iss_fire;

  // Counter values looked up by address; r15 has no counter and reads as 0.
  logic [CNT_W-1:0] iss_cnt;
  logic [CNT_W-1:0] wb_cnt;
  logic [CNT_W-1:0] ra1_cnt;
  logic [CNT_W-1:0] ra2_cnt;

  wb_rr_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (wb0_valid),
    .addr0   (wb0_addr),
    .req1    (wb1_valid),
    .addr1   (wb1_addr),
    .grant   (grant)
  );

  // Grants are only ever given to a valid requester, so a grant is a fire.
  assign wb0_ready = grant[0];
  assign wb1_ready = grant[1];
  assign wb_fire   = grant[0] | grant[1];
  assign wb_addr   = grant[1] ? wb1_addr : wb0_addr;
  assign wb_data   = grant[1] ? wb1_data : wb0_data;

  always_comb begin
    iss_cnt = '0;
    wb_cnt  = '0;
    ra1_cnt = '0;
    ra2_cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (iss_dst == AW'(i)) iss_cnt = cnt[i];
      if (wb_addr == AW'(i)) wb_cnt  = cnt[i];
      if (chk_ra1 == AW'(i)) ra1_cnt = cnt[i];
      if (chk_ra2 == AW'(i)) ra2_cnt = cnt[i];
    end
  end

  // Uses the current count only: a decrement landing this same edge does
  // not open a slot until the next cycle, which keeps the path short.
  assign iss_ready = is_pc(iss_dst) | (iss_cnt != CNT_MAX);
  assign iss_fire  = iss_valid & iss_ready & ~is_pc(iss_dst);

  // The writer's data lands on the falling edge after the counter drops,
  // ahead of decode's second-half read, so no bypass is needed.
  assign hazard = (~is_pc(chk_ra1) & (ra1_cnt != '0)) |
                  (~is_pc(chk_ra2) & (ra2_cnt != '0));

  // Scoreboard: issue and writeback to the same register cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (iss_fire && iss_dst == AW'(i)) begin
          if (!(wb_fire && wb_addr == AW'(i))) cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (wb_fire && wb_addr == AW'(i) && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // Registered write port and error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      rf_wd     <= '0;
      err_r15   <= 1'b0;
      err_unexp <= 1'b0;
    end else begin
      rf_we     <= wb_fire & ~is_pc(wb_addr);
      err_r15   <= wb_fire &  is_pc(wb_addr);
      // A same-edge issue to the same register makes that write expected.
      err_unexp <= wb_fire & ~is_pc(wb_addr) & (wb_cnt == '0) &
                   ~(iss_fire & (iss_dst == wb_addr));
      if (wb_fire && !is_pc(wb_addr)) begin
        rf_wa <= wb_addr;
        rf_wd <= wb_data;
      end
    end
  end

endmodule
